// File: rtl/bram_sdp.sv
// bram_sdp: simple-dual-port block RAM with one write port and one read port
// on a single clock. Features per-lane write enables, a read latency of 1 or 2,
// and a read-first collision policy.
// Optional feature macro: BRAM_INIT_CLEAR_EN. When defined, a zero-fill sweep
// runs after reset and init_busy is high while it runs. When undefined, the RAM
// is ready on the first edge after reset.
module bram_sdp #(
  parameter int LANE_WIDTH   = 8,
  parameter int LANES        = 1,
  parameter int ADDR_WIDTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [LANES-1:0]              wr_be,
  input  logic [LANE_WIDTH*LANES-1:0]   wr_data,
  input  logic                          rd_en,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic [LANE_WIDTH*LANES-1:0]   rd_data,
  output logic                          rd_valid,
  output logic                          init_busy
);

  localparam int DATA_WIDTH = LANE_WIDTH * LANES;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("bram_sdp: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [LANES-1:0]      mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;

`ifdef BRAM_INIT_CLEAR_EN
  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] ptr;

  // State register: reset always restarts the clear sweep
  always_ff @(posedge clk) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_next;
  end

  // Next state: leave CLEAR once the last address has been zeroed
  always_comb begin
    state_next = state;
    if (state == CLEAR && ptr == LAST_ADDR) state_next = READY;
  end

  // Clear pointer: walks 0..DEPTH-1 and parks on the last address
  always_ff @(posedge clk) begin
    if (!rst_n)                                ptr <= '0;
    else if (state == CLEAR && ptr != LAST_ADDR) ptr <= ptr + 1'b1;
  end

  assign ready     = (state == READY);
  assign init_busy = (state == CLEAR);
`else
  assign ready     = 1'b1;
  assign init_busy = 1'b0;
`endif

  // Write-port mux: the clear sweep owns the port until READY, user writes after
  always_comb begin
    mem_we    = wr_en & ready & rst_n;
    mem_waddr = wr_addr;
    mem_be    = wr_be;
    mem_wdata = wr_data;
`ifdef BRAM_INIT_CLEAR_EN
    if (state == CLEAR) begin
      mem_we    = rst_n;
      mem_waddr = ptr;
      mem_be    = '1;
      mem_wdata = '0;
    end
`endif
  end

  // Memory array: byte-lane masked write, contents are never reset directly
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (mem_we && mem_be[i])
        mem[mem_waddr][i*LANE_WIDTH +: LANE_WIDTH] <= mem_wdata[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  logic                  rd_fire;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  assign rd_fire = rd_en & ready & rst_n;

  // First read stage: nonblocking capture gives read-first on address collisions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) s1_data <= mem[rd_addr];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid;
      logic [DATA_WIDTH-1:0] s2_data;

      // Optional output register: adds one cycle and holds data between reads
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign rd_data  = s2_data;
      assign rd_valid = s2_valid;
    end else begin : g_lat1
      assign rd_data  = s1_data;
      assign rd_valid = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_bram_sdp.sv
// Testbench for bram_sdp. Two instances share the same stimulus: one with a
// read latency of 1 and one with a latency of 2, both with 4 lanes of 8 bits.
// Runs the clear-sweep checks when BRAM_INIT_CLEAR_EN is defined.
module tb_bram_sdp;

  localparam int LW = 8;
  localparam int LN = 4;
  localparam int AW = 4;
  localparam int DW = LW * LN;

`ifdef BRAM_INIT_CLEAR_EN
  localparam logic BUSY_AT_RESET = 1'b1;
`else
  localparam logic BUSY_AT_RESET = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [LN-1:0] wr_be = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic [DW-1:0] rd_data1, rd_data2;
  logic          rd_valid1, rd_valid2;
  logic          init_busy1, init_busy2;

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  bram_sdp #(.LANE_WIDTH(LW), .LANES(LN), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .init_busy(init_busy1)
  );

  bram_sdp #(.LANE_WIDTH(LW), .LANES(LN), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2),
    .rd_valid(rd_valid2), .init_busy(init_busy2)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [LN-1:0] be;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp;
  } vec_t;

  int compared = 0;
  int mismatched = 0;

  logic [DW-1:0] hold1 = '0;
  logic [DW-1:0] hold2 = '0;
  logic          pend_re = 1'b0;
  logic [DW-1:0] pend_exp = '0;
  logic          busy_err = 1'b0;
  logic          busy_rd_err = 1'b0;

  function automatic vec_t mk(logic we, logic [AW-1:0] wa, logic [LN-1:0] be,
                              logic [DW-1:0] wd, logic re, logic [AW-1:0] ra,
                              logic [DW-1:0] exp);
    vec_t v;
    v.we = we; v.wa = wa; v.be = be; v.wd = wd;
    v.re = re; v.ra = ra; v.exp = exp;
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs and sample just after the rising edge
  task automatic applyStimulus(input vec_t v);
    wr_en   = v.we;
    wr_addr = v.wa;
    wr_be   = v.be;
    wr_data = v.wd;
    rd_en   = v.re;
    rd_addr = v.ra;
    @(posedge clk);
    #1;
  endtask

  // Latency-1 result belongs to this vector, latency-2 result to the previous one
  task automatic checkOutput(input vec_t v, input string tag);
    if (v.re) begin
      checkValue({tag, " l1 valid"}, DW'(rd_valid1), DW'(1));
      checkValue({tag, " l1 data"}, rd_data1, v.exp);
      hold1 = v.exp;
    end else begin
      checkValue({tag, " l1 valid"}, DW'(rd_valid1), DW'(0));
      checkValue({tag, " l1 hold"}, rd_data1, hold1);
    end
    if (pend_re) begin
      checkValue({tag, " l2 valid"}, DW'(rd_valid2), DW'(1));
      checkValue({tag, " l2 data"}, rd_data2, pend_exp);
      hold2 = pend_exp;
    end else begin
      checkValue({tag, " l2 valid"}, DW'(rd_valid2), DW'(0));
      checkValue({tag, " l2 hold"}, rd_data2, hold2);
    end
    pend_re  = v.re;
    pend_exp = v.exp;
  endtask

  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput(v, tag);
  endtask

  task automatic idle(input string tag);
    runVec(mk(1'b0, '0, '0, '0, 1'b0, '0, '0), tag);
  endtask

  task automatic resetModel();
    hold1 = '0;
    hold2 = '0;
    pend_re = 1'b0;
    pend_exp = '0;
  endtask

  // Count cycles of init_busy after release while hammering both ports
  task automatic countBusy(input string tag);
    int cnt = 0;
    wr_en = 1'b1; wr_addr = 4'd3; wr_be = '1; wr_data = 32'hFFFF_FFFF;
    rd_en = 1'b1; rd_addr = 4'd3;
    while (init_busy1 && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (rd_valid1 || rd_valid2) busy_rd_err = 1'b1;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    checkValue({tag, " busy cycles"}, DW'(cnt), DW'(16));
    checkValue({tag, " busy l2 agrees"}, DW'(init_busy2), DW'(0));
  endtask

  // Macro-undefined build must never raise init_busy
  always @(negedge clk) begin
    if (!BUSY_AT_RESET && (init_busy1 !== 1'b0 || init_busy2 !== 1'b0)) busy_err = 1'b1;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t vecs[$];

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset l1 data", rd_data1, '0);
    checkValue("reset l1 valid", DW'(rd_valid1), DW'(0));
    checkValue("reset l2 data", rd_data2, '0);
    checkValue("reset l2 valid", DW'(rd_valid2), DW'(0));
    checkValue("reset busy", DW'(init_busy1), DW'(BUSY_AT_RESET));
    rst_n = 1'b1;

`ifdef BRAM_INIT_CLEAR_EN
    // Clear sweep duration, then every word must read back zero
    countBusy("sweep");
    for (int a = 0; a < 16; a++) runVec(mk(1'b0, '0, '0, '0, 1'b1, AW'(a), '0), $sformatf("clear rd%0d", a));
    idle("clear flush");
    checkValue("busy reads ignored", DW'(busy_rd_err), DW'(0));
`endif

    // Directed vectors in READY
    vecs.push_back(mk(1'b1, 4'd5, 4'b1111, 32'hAABB_CCDD, 1'b0, '0, '0));
    vecs.push_back(mk(1'b1, 4'd5, 4'b0101, 32'h1122_3344, 1'b0, '0, '0));
    vecs.push_back(mk(1'b0, '0, '0, '0, 1'b1, 4'd5, 32'hAA22_CC44));
    vecs.push_back(mk(1'b1, 4'd7, 4'b1111, 32'h0000_0055, 1'b0, '0, '0));
    vecs.push_back(mk(1'b1, 4'd7, 4'b1111, 32'h0000_0099, 1'b1, 4'd7, 32'h0000_0055));
    vecs.push_back(mk(1'b0, '0, '0, '0, 1'b1, 4'd7, 32'h0000_0099));
    vecs.push_back(mk(1'b1, 4'd0, 4'b1111, 32'h0000_0010, 1'b0, '0, '0));
    vecs.push_back(mk(1'b1, 4'd1, 4'b1111, 32'h0000_0011, 1'b0, '0, '0));
    vecs.push_back(mk(1'b1, 4'd2, 4'b1111, 32'h0000_0012, 1'b0, '0, '0));
    vecs.push_back(mk(1'b0, '0, '0, '0, 1'b1, 4'd0, 32'h0000_0010));
    vecs.push_back(mk(1'b0, '0, '0, '0, 1'b1, 4'd1, 32'h0000_0011));
    vecs.push_back(mk(1'b0, '0, '0, '0, 1'b1, 4'd2, 32'h0000_0012));
    vecs.push_back(mk(1'b1, 4'd2, 4'b1111, 32'h0000_003C, 1'b0, '0, '0));
    vecs.push_back(mk(1'b0, '0, '0, '0, 1'b1, 4'd2, 32'h0000_003C));
    vecs.push_back(mk(1'b1, 4'd1, 4'b0000, 32'hFFFF_FFFF, 1'b0, '0, '0));
    vecs.push_back(mk(1'b0, '0, '0, '0, 1'b1, 4'd1, 32'h0000_0011));
    vecs.push_back(mk(1'b0, '0, '0, '0, 1'b0, '0, '0));
    vecs.push_back(mk(1'b0, '0, '0, '0, 1'b0, '0, '0));
    for (int i = 0; i < vecs.size(); i++) runVec(vecs[i], $sformatf("vec%0d", i));

    // Reset while a latency-2 read is still in flight
    runVec(mk(1'b0, '0, '0, '0, 1'b1, 4'd5, 32'hAA22_CC44), "inflight issue");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkValue("inflight l1 valid", DW'(rd_valid1), DW'(0));
    checkValue("inflight l1 data", rd_data1, '0);
    checkValue("inflight l2 valid", DW'(rd_valid2), DW'(0));
    checkValue("inflight l2 data", rd_data2, '0);
    checkValue("inflight busy", DW'(init_busy1), DW'(BUSY_AT_RESET));
    resetModel();
    rst_n = 1'b1;

`ifdef BRAM_INIT_CLEAR_EN
    // Let the sweep reach ptr=9, then reset again and expect a full restart
    idle("resweep e0");
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkValue("midsweep busy", DW'(init_busy1), DW'(1));
    rst_n = 1'b1;
    countBusy("resweep");
    runVec(mk(1'b0, '0, '0, '0, 1'b1, 4'd5, '0), "resweep rd5");
    runVec(mk(1'b0, '0, '0, '0, 1'b1, 4'd3, '0), "resweep rd3");
    idle("resweep flush");
`else
    // Ready on the first edge after reset
    runVec(mk(1'b1, 4'd2, 4'b1111, 32'h0000_003C, 1'b0, '0, '0), "postrst wr");
    runVec(mk(1'b0, '0, '0, '0, 1'b1, 4'd2, 32'h0000_003C), "postrst rd");
    idle("postrst flush");
`endif

    checkValue("busy never set", DW'(busy_err), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bram_sdp.md
# bram_sdp

Simple-dual-port block RAM for the convolution datapath: one write port and one independent read port on a single clock, with per-lane write enables, selectable read latency and a post-reset clear sweep. It generalises the single-port 8-bit buffer used for weights and activations. It sits between the input loader and the systolic PE array, so a new input window can be written while the array reads the current one.

## Interface
- LANE_WIDTH, 8, bits per byte lane
- LANES, 1, lanes per word; DATA_WIDTH = LANE_WIDTH*LANES
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words
- READ_LATENCY, 1, cycles from rd_en to rd_valid; legal values 1 or 2, anything else is an elaboration error
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- wr_en  input  1  write request
- wr_addr  input  ADDR_WIDTH  write address
- wr_be  input  LANES  per-lane write enable; lane i covers bits [i*LANE_WIDTH +: LANE_WIDTH]
- wr_data  input  DATA_WIDTH  write data
- rd_en  input  1  read request
- rd_addr  input  ADDR_WIDTH  read address
- rd_data  output  DATA_WIDTH  read data, registered
- rd_valid  output  1  one-cycle pulse marking valid rd_data
- init_busy  output  1  high while the clear sweep runs; requests are ignored

## Operation
- FSM states: CLEAR and READY.
- Reset (rst_n low at a rising edge):
  - FSM goes to CLEAR; clear pointer goes to 0.
  - Read pipeline is flushed: rd_valid = 0, rd_data = 0.
  - init_busy = 1.
  - Memory array is not reset directly.
- CLEAR:
  - Each cycle, writes all-zero to mem[ptr] with all lanes enabled, then increments ptr.
  - After writing ptr = DEPTH-1, moves to READY.
  - wr_en and rd_en are ignored. Requests are dropped, not queued.
- READY:
  - Write with wr_en=1: each lane i with wr_be[i]=1 is updated; other lanes keep their contents. wr_en=1 with wr_be=0 changes nothing.
  - Read with rd_en=1: captures mem[rd_addr]. The data appears on rd_data with rd_valid=1 exactly READY_LATENCY cycles later.
  - Reads are fully pipelined: one accepted per cycle, with no back-pressure.
  - When no read completes, rd_data holds its last value and rd_valid = 0.
- Collisions: a read and a write to the same address in the same cycle return the old contents (read-first). The new data is visible to a read issued in the next cycle or later.
- Address wrap: addresses are plain ADDR_WIDTH-bit values with no bounds check. The clear pointer does not wrap; it terminates at DEPTH-1.
- Reset mid-sweep or mid-read: the sweep restarts from 0, and any in-flight read is discarded (no rd_valid pulse).

## Timing
- Reset values: rd_data = 0, rd_valid = 0, init_busy = 1.
- rst_n rises before edge E0:
  - Clear writes addresses 0..DEPTH-1 on edges E0..E(DEPTH-1).
  - init_busy falls after E(DEPTH-1).
  - The first accepted request is at E(DEPTH).
- READY_LATENCY=1: rd_en sampled at edge N gives rd_data/rd_valid valid after edge N, for one cycle.
- READY_LATENCY=2: an extra output register is added, so the result is valid after edge N+1.
- Write latency: a write at edge N is readable by a rd_en sampled at edge N+1.
- Throughput: one write plus one read per cycle in READY.

## Configuration
- BRAM_INIT_CLEAR_EN:
  - Defined: the CLEAR sweep and init_busy behave as above.
  - Undefined: there is no CLEAR state and init_busy is tied to 0. The block is READY from the first edge after reset. Memory contents are unspecified (X in simulation) until written; the read pipeline still resets rd_data/rd_valid to 0.

## Test plan
- Clear sweep, macro defined, ADDR_WIDTH=4: release reset, then:
  - init_busy must be high for exactly 16 cycles.
  - Reads of all 16 addresses must return 0x00.
  - A write issued during busy must be lost: addr 3 still reads 0.
- Lane enables, LANES=4: write 0xAABBCCDD to addr 5 with wr_be=4'b1111, then 0x11223344 with wr_be=4'b0101. Reading addr 5 must return 0xAA22CC44.
- Read-first collision: mem[7]=0x55. At the same edge write 0x99 to addr 7 and read addr 7. The read returns 0x55; the read on the next cycle returns 0x99.
- Latency and throughput:
  - READY_LATENCY=2: back-to-back reads of addrs 0,1,2 (preloaded 0x10,0x11,0x12) produce rd_valid on 3 consecutive cycles starting 2 cycles after the first rd_en, with data 0x10,0x11,0x12.
  - Repeat at latency 1 with a 1-cycle offset.
- Reset mid-operation:
  - Assert rst_n low for 1 cycle while a read is in flight and the sweep is at ptr=9.
  - No rd_valid pulse may appear; rd_data = 0.
  - The sweep restarts at 0, and init_busy is high for 16 cycles after release.
- Macro undefined: after reset, init_busy = 0 constantly. A write of 0x3C to addr 2 followed by a read returns 0x3C one cycle after rd_en.
